// File: rtl/ifft8_seq.sv
`timescale 1ns/1ps
// ifft8_seq
// Sequential 8-point radix-2 DIT inverse FFT built around one shared butterfly.
// Bins arrive in natural order and are stored bit-reversed. Three stages of four
// butterflies each (12 cycles) run in place with a 1/2 scale per stage, which
// gives a true 1/8-scaled IFFT. Samples then leave in natural order.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, ACTIVE-HIGH despite the name
//   in_valid   input bin present
//   in_ready   bin accepted this cycle (high only while loading)
//   in_r/in_i  bin real / imaginary part, DW-bit signed
//   out_valid  output sample present
//   out_ready  downstream accepts the sample
//   out_r/out_i sample real / imaginary part, DW-bit signed
//   out_last   high with sample 7
//   busy       high while computing or emitting
module ifft8_seq #(
  parameter int DW = 12,
  parameter int TW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_last,
  output logic                 busy
);

  localparam int FB = TW - 2;       // fraction bits of the Q2.x twiddle
  localparam int MW = DW + TW + 1;  // full complex-product width
  localparam int PW = DW + 2;       // width the scaled product is held at
  localparam int SW = PW + 1;       // butterfly sum width

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t r_state, w_state_next;
  logic [2:0] r_cnt;
  logic [3:0] r_bcnt;
  logic [2:0] r_ocnt;
  logic signed [DW-1:0] r_re [8];
  logic signed [DW-1:0] r_im [8];

  // Butterfly address / twiddle decode: stage = bcnt[3:2], butterfly j = bcnt[1:0]
  logic [1:0] w_stage, w_j, w_t;
  logic [2:0] w_p, w_q;
  assign w_stage = r_bcnt[3:2];
  assign w_j     = r_bcnt[1:0];

  always_comb begin
    w_p = {w_j, 1'b0};
    w_q = {w_j, 1'b1};
    w_t = 2'd0;
    case (w_stage)
      2'd0: begin  // span 1: pairs (2j, 2j+1), twiddle 0
        w_p = {w_j, 1'b0};
        w_q = {w_j, 1'b1};
        w_t = 2'd0;
      end
      2'd1: begin  // span 2: group j[1], offset j[0], twiddle 2*offset
        w_p = {w_j[1], 1'b0, w_j[0]};
        w_q = {w_j[1], 1'b1, w_j[0]};
        w_t = {w_j[0], 1'b0};
      end
      default: begin  // span 4: single group, twiddle = offset
        w_p = {1'b0, w_j};
        w_q = {1'b1, w_j};
        w_t = w_j;
      end
    endcase
  end

  // Conjugate twiddles W^-t
  logic signed [TW-1:0] w_wr, w_wi;
  always_comb begin
    w_wr = TW'(1024);
    w_wi = '0;
    case (w_t)
      2'd0: begin w_wr = TW'(1024);  w_wi = TW'(0);    end
      2'd1: begin w_wr = TW'(724);   w_wi = TW'(724);  end
      2'd2: begin w_wr = TW'(0);     w_wi = TW'(1024); end
      default: begin w_wr = -TW'(724); w_wi = TW'(724); end
    endcase
  end

  // Operands, sign-extended to the product width
  logic signed [DW-1:0] w_ar, w_ai, w_br, w_bi;
  assign w_ar = r_re[w_p];
  assign w_ai = r_im[w_p];
  assign w_br = r_re[w_q];
  assign w_bi = r_im[w_q];

  logic signed [MW-1:0] w_br_x, w_bi_x, w_wr_x, w_wi_x, w_pr_full, w_pi_full;
  assign w_br_x = {{(MW-DW){w_br[DW-1]}}, w_br};
  assign w_bi_x = {{(MW-DW){w_bi[DW-1]}}, w_bi};
  assign w_wr_x = {{(MW-TW){w_wr[TW-1]}}, w_wr};
  assign w_wi_x = {{(MW-TW){w_wi[TW-1]}}, w_wi};
  assign w_pr_full = w_br_x * w_wr_x - w_bi_x * w_wi_x;
  assign w_pi_full = w_br_x * w_wi_x + w_bi_x * w_wr_x;

  // Slicing off the fraction bits is a floor shift for two's complement
  logic signed [PW-1:0] w_pr, w_pi;
  assign w_pr = w_pr_full[FB+PW-1:FB];
  assign w_pi = w_pi_full[FB+PW-1:FB];

  logic signed [SW-1:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  assign w_sum_r = {{(SW-DW){w_ar[DW-1]}}, w_ar} + {w_pr[PW-1], w_pr};
  assign w_sum_i = {{(SW-DW){w_ai[DW-1]}}, w_ai} + {w_pi[PW-1], w_pi};
  assign w_dif_r = {{(SW-DW){w_ar[DW-1]}}, w_ar} - {w_pr[PW-1], w_pr};
  assign w_dif_i = {{(SW-DW){w_ai[DW-1]}}, w_ai} - {w_pi[PW-1], w_pi};

  // Clamp a PW-bit value to DW bits: overflow when the top three bits disagree
  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1:DW-1] == '0 || v[PW-1:DW-1] == '1) sat = v[DW-1:0];
    else if (v[PW-1])                               sat = {1'b1, {(DW-1){1'b0}}};
    else                                            sat = {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Dropping bit 0 of the sum is the floor halving
  logic signed [DW-1:0] w_a_r, w_a_i, w_b_r, w_b_i;
  assign w_a_r = sat(w_sum_r[SW-1:1]);
  assign w_a_i = sat(w_sum_i[SW-1:1]);
  assign w_b_r = sat(w_dif_r[SW-1:1]);
  assign w_b_i = sat(w_dif_i[SW-1:1]);

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_cnt == 3'd7) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_bcnt == 4'd11) w_state_next = S_OUT;
      end
      default: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && r_ocnt == 3'd7) w_state_next = S_LOAD;
      end
    endcase
  end

  assign out_r    = out_valid ? r_re[r_ocnt] : '0;
  assign out_i    = out_valid ? r_im[r_ocnt] : '0;
  assign out_last = out_valid && (r_ocnt == 3'd7);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_ocnt  <= '0;
      for (int n = 0; n < 8; n++) begin
        r_re[n] <= '0;
        r_im[n] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            // bins land bit-reversed so the DIT stages read them in place
            r_re[{r_cnt[0], r_cnt[1], r_cnt[2]}] <= in_r;
            r_im[{r_cnt[0], r_cnt[1], r_cnt[2]}] <= in_i;
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_CALC: begin
          r_re[w_p] <= w_a_r;
          r_im[w_p] <= w_a_i;
          r_re[w_q] <= w_b_r;
          r_im[w_q] <= w_b_i;
          r_bcnt    <= (r_bcnt == 4'd11) ? 4'd0 : r_bcnt + 4'd1;
        end
        default: begin
          if (out_ready) r_ocnt <= r_ocnt + 3'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
`timescale 1ns/1ps
// Self-checking bench for ifft8_seq: a driver feeds frames with random in_valid
// gaps, a scoreboard queue holds expected samples, and a monitor with random
// out_ready pops and compares every accepted output beat.
module tb_ifft8_seq;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_r, in_i, out_r, out_i;

  ifft8_seq #(.DW(DW), .TW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int r; int i; bit last; } samp_t;
  samp_t exp_q[$];

  int bin_r[8], bin_i[8];   // frame being sent
  int c_r[8], c_i[8];       // hand-derived expected samples
  int push_mode = 0;        // 0: expect nothing, 1: constants, 2: reference model
  int lastbeat_cyc = -1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model: textbook in-place DIT IFFT ----------------
  int tw_r[4] = '{1024, 724, 0, -724};
  int tw_i[4] = '{0, 724, 1024, 724};

  function automatic int clamp(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int bitrev3(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  task automatic model_push();
    int xr[8], xi[8];
    int pr, pi, ar, ai, br, bi, wr, wi;
    samp_t s;
    for (int n = 0; n < 8; n++) begin
      xr[bitrev3(n)] = bin_r[n];
      xi[bitrev3(n)] = bin_i[n];
    end
    for (int h = 1; h < 8; h = h * 2)
      for (int g = 0; g < 8; g = g + 2 * h)
        for (int k = 0; k < h; k++) begin
          wr = tw_r[k * (4 / h)];
          wi = tw_i[k * (4 / h)];
          ar = xr[g + k];     ai = xi[g + k];
          br = xr[g + k + h]; bi = xi[g + k + h];
          pr = (br * wr - bi * wi) >>> 10;
          pi = (br * wi + bi * wr) >>> 10;
          xr[g + k]     = clamp((ar + pr) >>> 1);
          xi[g + k]     = clamp((ai + pi) >>> 1);
          xr[g + k + h] = clamp((ar - pr) >>> 1);
          xi[g + k + h] = clamp((ai - pi) >>> 1);
        end
    for (int n = 0; n < 8; n++) begin
      s.r = xr[n]; s.i = xi[n]; s.last = (n == 7);
      exp_q.push_back(s);
    end
  endtask

  task automatic const_push();
    samp_t s;
    for (int n = 0; n < 8; n++) begin
      s.r = c_r[n]; s.i = c_i[n]; s.last = (n == 7);
      exp_q.push_back(s);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_frame();
    int i = 0;
    int guard = 0;
    while (i < 8) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        $display("FAIL send_timeout: got %0d beats, required 8", i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "driver stalled");
      end
      if (in_ready && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_r = DW'(bin_r[i]);
        in_i = DW'(bin_i[i]);
        if (i == 7) begin
          lastbeat_cyc = cyc;
          if (push_mode == 1) const_push();
          else if (push_mode == 2) model_push();
        end
        i++;
      end else begin
        // junk while not ready must be ignored
        in_valid = (!in_ready) && ($urandom_range(0, 1) == 1);
        in_r = DW'($urandom);
        in_i = DW'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic set_bins_zero();
    for (int n = 0; n < 8; n++) begin bin_r[n] = 0; bin_i[n] = 0; end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_size", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  bit hold_pending = 0;
  bit prev_valid = 0;
  int hold_r, hold_i, hold_last;

  initial begin
    samp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hold_pending = 0;
        prev_valid   = 0;
        out_ready    = 1'b0;
      end else begin
        if (busy) check("in_ready_while_busy", int'(in_ready), 0);
        if (hold_pending) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_r", int'(out_r), hold_r);
          check("hold_i", int'(out_i), hold_i);
          check("hold_last", int'(out_last), hold_last);
        end
        if (out_valid && !prev_valid && lastbeat_cyc >= 0)
          check("latency", cyc - lastbeat_cyc, 13);
        prev_valid = out_valid;
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          hold_pending = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_r", int'(out_r), e.r);
            check("out_i", int'(out_i), e.i);
            check("out_last", int'(out_last), int'(e.last));
            $display("[TB] sample r=%0d i=%0d last=%0d exp r=%0d i=%0d last=%0d",
                     out_r, out_i, out_last, e.r, e.i, e.last);
          end
        end else if (out_valid) begin
          hold_pending = 1;
          hold_r = int'(out_r);
          hold_i = int'(out_i);
          hold_last = int'(out_last);
        end else begin
          hold_pending = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_i", int'(out_i), 0);
    rst_n = 1'b0;

    // impulse at bin 0 -> flat 100
    set_bins_zero(); bin_r[0] = 800;
    for (int n = 0; n < 8; n++) begin c_r[n] = 100; c_i[n] = 0; end
    push_mode = 1; send_frame();

    // bin 2 -> quarter-rate rotation, twice
    set_bins_zero(); bin_r[2] = 800;
    for (int n = 0; n < 8; n++) begin
      c_r[n] = (n % 4 == 0) ? 100 : (n % 4 == 2) ? -100 : 0;
      c_i[n] = (n % 4 == 1) ? 100 : (n % 4 == 3) ? -100 : 0;
    end
    send_frame();

    // full-scale DC -> 2047 at sample 0, no wrap
    for (int n = 0; n < 8; n++) begin
      bin_r[n] = 2047; bin_i[n] = 0;
      c_r[n] = (n == 0) ? 2047 : 0; c_i[n] = 0;
    end
    send_frame();

    // bin 1 -> eighth-rate rotation with 45-degree twiddles, via the model
    set_bins_zero(); bin_r[1] = 800;
    push_mode = 2; send_frame();

    // random back-to-back frames over the full signed range
    for (int f = 0; f < 16; f++) begin
      for (int n = 0; n < 8; n++) begin
        bin_r[n] = $urandom_range(0, 4095) - 2048;
        bin_i[n] = $urandom_range(0, 4095) - 2048;
      end
      send_frame();
    end
    wait_drain();

    // reset in the middle of CALC: the frame is abandoned
    set_bins_zero(); bin_r[0] = 800;
    push_mode = 0; send_frame();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int n = 0; n < 8; n++) begin c_r[n] = 100; c_i[n] = 0; end
    push_mode = 1; send_frame();
    wait_drain();
    repeat (5) @(negedge clk);
    check("final_out_valid", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, required finish", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
